// File: rtl/lag_scan_sequencer.sv
// lag_scan_sequencer: deterministic, abortable delay-lag scan scheduler for one correlator channel.
//
// The lag steps from scan_start by scan_inc towards scan_start + scan_len (saturated to all-ones).
// Every lag point runs three phases in order: settle, integrate, then a capture handshake.
//
// Ports:
//   pllclk        sole clock, rising edge
//   reset_n       asynchronous active-low reset
//   start         one-cycle scan request; honoured only in IDLE
//   abort         ends the scan at once; ignored in IDLE
//   repeat_scan   continuous-scan request (only with LAG_SCAN_REPEAT_EN)
//   scan_start    first lag value (latched on start)
//   scan_len      scan span (latched on start)
//   scan_inc      lag step (latched on start)
//   integ_cycles  integration length per point in pllclk cycles; 0 acts as 1
//   capture_ack   TX path accepted the capture
//   lag_out       current lag value
//   integrate     high while integrating
//   capture_req   capture request for the current point
//   busy          high in any state other than IDLE
//   done          one-cycle pulse when a scan completes
//   aborted       one-cycle pulse when a scan is aborted
//   step_count    number of points completed in the current scan
//
// Build option: define LAG_SCAN_REPEAT_EN to restart the scan from scan_start when it reaches
// the end with repeat_scan=1. Without the macro, repeat_scan is unused.
module lag_scan_sequencer #(
  parameter int unsigned LAG_WIDTH     = 20,
  parameter int unsigned INC_WIDTH     = 12,
  parameter int unsigned INTEG_WIDTH   = 32,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned STEP_WIDTH    = 16
) (
  input  logic                   pllclk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   repeat_scan,
  input  logic [LAG_WIDTH-1:0]   scan_start,
  input  logic [LAG_WIDTH-1:0]   scan_len,
  input  logic [INC_WIDTH-1:0]   scan_inc,
  input  logic [INTEG_WIDTH-1:0] integ_cycles,
  input  logic                   capture_ack,
  output logic [LAG_WIDTH-1:0]   lag_out,
  output logic                   integrate,
  output logic                   capture_req,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [STEP_WIDTH-1:0]  step_count
);

  localparam logic [INTEG_WIDTH-1:0] SettleLast = INTEG_WIDTH'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StSettle, StIntegrate, StCapture, StStep, StDone} state_e;

  state_e                 state;
  logic [LAG_WIDTH-1:0]   start_lag;
  logic [LAG_WIDTH-1:0]   end_lag;
  logic [INC_WIDTH-1:0]   inc_lat;
  logic [INTEG_WIDTH-1:0] integ_last;
  logic [INTEG_WIDTH-1:0] cnt;

  logic [LAG_WIDTH:0]     end_sum;
  logic [LAG_WIDTH-1:0]   end_cfg;
  logic [LAG_WIDTH:0]     next_sum;
  logic                   scan_last;

  // The extra top bit catches overflow so the end point saturates instead of wrapping.
  assign end_sum  = {1'b0, scan_start} + {1'b0, scan_len};
  assign end_cfg  = end_sum[LAG_WIDTH] ? '1 : end_sum[LAG_WIDTH-1:0];
  assign next_sum = {1'b0, lag_out} + {{(LAG_WIDTH + 1 - INC_WIDTH){1'b0}}, inc_lat};
  // A carried sum always exceeds end_lag, so this compare also covers overflow.
  assign scan_last = (inc_lat == '0) || (next_sum >= {1'b0, end_lag});

`ifndef LAG_SCAN_REPEAT_EN
  logic unused_repeat;
  assign unused_repeat = repeat_scan;
`endif

  always_ff @(posedge pllclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= StIdle;
      lag_out     <= '0;
      integrate   <= 1'b0;
      capture_req <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      step_count  <= '0;
      start_lag   <= '0;
      end_lag     <= '0;
      inc_lat     <= '0;
      integ_last  <= '0;
      cnt         <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (abort && (state != StIdle)) begin
        // Abort outranks everything, including a coincident capture_ack.
        state       <= StIdle;
        integrate   <= 1'b0;
        capture_req <= 1'b0;
        busy        <= 1'b0;
        aborted     <= 1'b1;
        cnt         <= '0;
      end else begin
        unique case (state)
          StIdle: begin
            if (start) begin
              start_lag  <= scan_start;
              end_lag    <= end_cfg;
              inc_lat    <= scan_inc;
              integ_last <= (integ_cycles == '0) ? '0 : integ_cycles - 1'b1;
              lag_out    <= scan_start;
              step_count <= '0;
              cnt        <= '0;
              busy       <= 1'b1;
              state      <= StSettle;
            end
          end
          StSettle: begin
            if (cnt == SettleLast) begin
              cnt       <= '0;
              integrate <= 1'b1;
              state     <= StIntegrate;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          StIntegrate: begin
            if (cnt == integ_last) begin
              cnt         <= '0;
              integrate   <= 1'b0;
              capture_req <= 1'b1;
              state       <= StCapture;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          StCapture: begin
            if (capture_ack) begin
              capture_req <= 1'b0;
              step_count  <= step_count + 1'b1;
              state       <= StStep;
            end
          end
          StStep: begin
            if (scan_last) begin
              done <= 1'b1;
`ifdef LAG_SCAN_REPEAT_EN
              if (repeat_scan) begin
                lag_out    <= start_lag;
                step_count <= '0;
                state      <= StSettle;
              end else begin
                state <= StDone;
              end
`else
              state <= StDone;
`endif
            end else begin
              lag_out <= next_sum[LAG_WIDTH-1:0];
              state   <= StSettle;
            end
          end
          StDone: begin
            busy  <= 1'b0;
            state <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lag_scan_sequencer.sv
module tb_lag_scan_sequencer;

  localparam int unsigned Settle  = 4;
  localparam int unsigned LagMax  = 20'hFFFFF;

  logic        pllclk = 1'b0;
  logic        reset_n;
  logic        start, abort, repeat_scan, capture_ack;
  logic [19:0] scan_start, scan_len;
  logic [11:0] scan_inc;
  logic [31:0] integ_cycles;
  logic [19:0] lag_out;
  logic        integrate, capture_req, busy, done, aborted;
  logic [15:0] step_count;

  int n_vec = 0;
  int n_err = 0;
  int unsigned exp_pts[$];

  lag_scan_sequencer dut (
    .pllclk       (pllclk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .repeat_scan  (repeat_scan),
    .scan_start   (scan_start),
    .scan_len     (scan_len),
    .scan_inc     (scan_inc),
    .integ_cycles (integ_cycles),
    .capture_ack  (capture_ack),
    .lag_out      (lag_out),
    .integrate    (integrate),
    .capture_req  (capture_req),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .step_count   (step_count)
  );

  always #5 pllclk = ~pllclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled and inputs driven on the falling edge.
  task automatic tick();
    @(negedge pllclk);
  endtask

  task automatic scramble();
    scan_start   = 20'($urandom);
    scan_len     = 20'($urandom);
    scan_inc     = 12'($urandom);
    integ_cycles = $urandom;
  endtask

  // Lag points a scan must visit, from plain arithmetic on the scan parameters.
  task automatic build_points(input int unsigned s, input int unsigned len, input int unsigned inc);
    int unsigned e;
    int unsigned p;
    exp_pts.delete();
    e = s + len;
    if (e > LagMax) e = LagMax;
    p = s;
    for (int k = 0; k < 64; k++) begin
      exp_pts.push_back(p);
      if (inc == 0 || p + inc >= e) break;
      p = p + inc;
    end
  endtask

  task automatic run_scan(input logic [19:0] s, input logic [19:0] len, input logic [11:0] inc,
                          input logic [31:0] integ, input bit abort_cap);
    int n;
    int settle;
    int ilen;
    int last;
    build_points(s, len, inc);
    ilen = (integ == 0) ? 1 : int'(integ);
    last = exp_pts.size() - 1;
    scan_start = s; scan_len = len; scan_inc = inc; integ_cycles = integ; start = 1'b1;
    tick();
    start = 1'b0;
    scramble();
    check_eq("busy_after_start", busy, 1);
    check_eq("step_count_cleared", step_count, 0);
    for (int i = 0; i <= last; i++) begin
      check_eq("lag_point", lag_out, exp_pts[i]);
      check_eq("done_mid_scan", done, 0);
      settle = 0;
      while (!integrate && settle < 64) begin
        settle++;
        capture_ack = 1'($urandom_range(0, 1));
        start = ($urandom_range(0, 3) == 0);
        scramble();
        tick();
      end
      start = 1'b0;
      check_eq("settle_len", settle, Settle);
      n = 0;
      while (integrate && n < 64) begin
        n++;
        capture_ack = 1'($urandom_range(0, 1));
        tick();
      end
      capture_ack = 1'b0;
      check_eq("integ_len", n, ilen);
      check_eq("capture_req_rise", capture_req, 1);
      check_eq("lag_at_capture", lag_out, exp_pts[i]);
      if (abort_cap) begin
        repeat (50) begin
          tick();
          check_eq("capture_req_held", capture_req, 1);
        end
        check_eq("lag_while_waiting", lag_out, exp_pts[i]);
        check_eq("step_while_waiting", step_count, i);
        abort = 1'b1;
        capture_ack = 1'b1;
        tick();
        abort = 1'b0;
        capture_ack = 1'b0;
        check_eq("aborted_pulse", aborted, 1);
        check_eq("busy_after_abort", busy, 0);
        check_eq("req_after_abort", capture_req, 0);
        check_eq("step_after_abort", step_count, i);
        check_eq("lag_after_abort", lag_out, exp_pts[i]);
        check_eq("no_done_on_abort", done, 0);
        tick();
        check_eq("aborted_one_cycle", aborted, 0);
        return;
      end
      repeat ($urandom_range(0, 3)) tick();
      check_eq("capture_req_wait", capture_req, 1);
      capture_ack = 1'b1;
      tick();
      capture_ack = 1'b0;
      check_eq("capture_req_drop", capture_req, 0);
      check_eq("step_count_inc", step_count, i + 1);
      tick();
    end
    check_eq("done_pulse", done, 1);
    check_eq("busy_in_done", busy, 1);
    check_eq("lag_held_end", lag_out, exp_pts[last]);
    tick();
    check_eq("done_one_cycle", done, 0);
    check_eq("busy_idle", busy, 0);
    check_eq("step_count_final", step_count, last + 1);
  endtask

  initial begin
    logic [19:0] s, len;
    logic [11:0] inc;
    int          bound;
    reset_n = 1'b0;
    start = 0; abort = 0; repeat_scan = 0; capture_ack = 0;
    scan_start = 0; scan_len = 0; scan_inc = 0; integ_cycles = 0;
    tick();
    tick();
    check_eq("rst_lag", lag_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_integ", integrate, 0);
    check_eq("rst_req", capture_req, 0);
    check_eq("rst_pulses", {done, aborted}, 0);
    check_eq("rst_step", step_count, 0);
    reset_n = 1'b1;
    tick();

    run_scan(20'd10, 20'd30, 12'd10, 32'd5, 1'b0);
    run_scan(20'd0, 20'd0, 12'd7, 32'd3, 1'b0);
    run_scan(20'hFFFF0, 20'h20, 12'h10, 32'd2, 1'b0);
    run_scan(20'd500, 20'd100, 12'd0, 32'd0, 1'b0);

    // abort while idle is a no-op
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("idle_abort_pulse", aborted, 0);
    check_eq("idle_abort_busy", busy, 0);

    run_scan(20'd40, 20'd100, 12'd20, 32'd2, 1'b1);

    // asynchronous reset in the middle of integration
    scan_start = 20'd10; scan_len = 20'd30; scan_inc = 12'd10; integ_cycles = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    bound = 0;
    while (!integrate && bound < 32) begin
      bound++;
      tick();
    end
    check_eq("reached_integrate", integrate, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_integ", integrate, 0);
    check_eq("async_rst_lag", lag_out, 0);
    check_eq("async_rst_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    tick();
    run_scan(20'd10, 20'd30, 12'd10, 32'd5, 1'b0);

    for (int t = 0; t < 30; t++) begin
      s = ($urandom_range(0, 3) == 0) ? 20'(LagMax - $urandom_range(0, 8000)) : 20'($urandom);
      inc = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
      len = 20'($urandom_range(0, int'(inc) * 5 + 3));
      run_scan(s, len, inc, 32'($urandom_range(0, 6)), ($urandom_range(0, 9) == 0));
      repeat ($urandom_range(0, 2)) tick();
    end

`ifdef LAG_SCAN_REPEAT_EN
    begin
      int ndone = 0;
      repeat_scan = 1'b1;
      capture_ack = 1'b1;
      scan_start = 20'd100; scan_len = 20'd20; scan_inc = 12'd10; integ_cycles = 32'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 200 && ndone < 2; c++) begin
        check_eq("repeat_busy", busy, 1);
        if (done) begin
          ndone++;
          check_eq("repeat_lag_wrap", lag_out, 100);
          check_eq("repeat_step_clear", step_count, 0);
        end
        tick();
      end
      check_eq("repeat_done_count", ndone, 2);
      capture_ack = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      repeat_scan = 1'b0;
      check_eq("repeat_aborted", aborted, 1);
      check_eq("repeat_busy_drop", busy, 0);
      tick();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
